// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundle of the per-requester valid/ready write-request signals that feed
//   regfile_write_arbiter.
//
//   req_valid  [NREQ]          per-requester write request
//   req_addr   [NREQ*ADDR_W]   target register, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   [NREQ*DATA_W]   write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  [NREQ]          one-hot grant back to the requesters
//
//   master : requester side (drives valid/addr/data, observes ready)
//   slave  : arbiter side   (observes valid/addr/data, drives ready)
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Owns the single write port of the register file and shares it among NREQ
//   requesters with valid/ready round-robin arbitration. After reset, or when
//   reinit is pulsed, an init sequencer writes INIT_VAL into every register
//   before arbitration opens. Every accepted request reaches the register file
//   exactly one cycle after its handshake.
//
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   req         request bundle (slave modport): req_valid/req_addr/req_data in,
//               req_ready out (combinational, one-hot)
//   reinit      restart the init sequence
//   busy        high while the init sequence is running
//   reg_w       register file write address   (registered)
//   write_data  register file write data      (registered)
//   do_write    register file write enable    (registered)
//
//   Build option: define ARB_FIXED_PRIO_EN to replace round-robin with fixed
//   priority (lowest index wins); the round-robin pointer is then removed.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int NREQ     = 3,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 8,
  parameter int INIT_VAL = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  regfile_write_arbiter_if.slave   req,
  input  logic                     reinit,
  output logic                     busy,
  output logic [ADDR_W-1:0]        reg_w,
  output logic [DATA_W-1:0]        write_data,
  output logic                     do_write
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {ST_INIT, ST_ARB} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                do_write_q, do_write_d;
  logic [ADDR_W-1:0]   reg_w_q, reg_w_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
`ifndef ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

  logic                found;
  int                  gnt;
  logic [NREQ-1:0]     grant;

  // Winner search: first valid requester starting at the priority pointer.
  // The candidate index is wrapped with a compare-and-subtract so that
  // non-power-of-two NREQ never aliases onto a non-existent requester.
  always_comb begin
    found = 1'b0;
    gnt   = 0;
    for (int k = 0; k < NREQ; k++) begin
      int cand;
`ifdef ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
`endif
      if (!found && req.req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d      = state_q;
    idx_d        = idx_q;
    do_write_d   = 1'b0;
    reg_w_d      = reg_w_q;
    write_data_d = write_data_q;
    grant        = '0;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif

    unique case (state_q)
      ST_INIT: begin
        do_write_d   = 1'b1;
        reg_w_d      = ADDR_W'(idx_q);
        write_data_d = DATA_W'(INIT_VAL);
        if (reinit) begin
          idx_d = '0;
        end else if (idx_q == IDX_W'(NUM_REGS - 1)) begin
          idx_d   = '0;
          state_d = ST_ARB;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_ARB: begin
        // reinit blocks the grant so nothing is accepted in the cycle that
        // hands the port back to the init sequencer.
        if (reinit) begin
          idx_d   = '0;
          state_d = ST_INIT;
        end else if (found) begin
          grant[gnt]   = 1'b1;
          do_write_d   = 1'b1;
          reg_w_d      = req.req_addr[gnt*ADDR_W +: ADDR_W];
          write_data_d = req.req_data[gnt*DATA_W +: DATA_W];
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_d     = (gnt == NREQ - 1) ? '0 : PTR_W'(gnt + 1);
`endif
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      do_write_q   <= 1'b0;
      reg_w_q      <= '0;
      write_data_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      do_write_q   <= do_write_d;
      reg_w_q      <= reg_w_d;
      write_data_q <= write_data_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign req.req_ready = grant;
  assign busy          = (state_q == ST_INIT);
  assign do_write      = do_write_q;
  assign reg_w         = reg_w_q;
  assign write_data    = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter (NREQ=3, NUM_REGS=4, 2-bit
//   address, 8-bit data, INIT_VAL=0). Inputs change on the falling edge;
//   ready is sampled 1 ns after that, registered outputs 1 ns after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reinit;
  logic       busy;
  logic [1:0] reg_w;
  logic [7:0] write_data;
  logic       do_write;

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter_if #(.NREQ(3), .ADDR_W(2), .DATA_W(8)) bus ();

  regfile_write_arbiter #(
    .NREQ(3), .NUM_REGS(4), .ADDR_W(2), .DATA_W(8), .INIT_VAL(0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (bus.slave),
    .reinit     (reinit),
    .busy       (busy),
    .reg_w      (reg_w),
    .write_data (write_data),
    .do_write   (do_write)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (do_write !== 1'b0) begin errors++; $display("FAIL rst_do_write: got %b want 0", do_write); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    checks++; if (reg_w !== 2'd0) begin errors++; $display("FAIL rst_reg_w: got %0d want 0", reg_w); end
    checks++; if (write_data !== 8'h00) begin errors++; $display("FAIL rst_write_data: got %h want 00", write_data); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready: got %b want 000", bus.req_ready); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (do_write !== 1'b1) begin errors++; $display("FAIL init_do_write[%0d]: got %b want 1", k, do_write); end
      checks++; if (reg_w !== 2'(k)) begin errors++; $display("FAIL init_reg_w[%0d]: got %0d want %0d", k, reg_w, k); end
      checks++; if (write_data !== 8'h00) begin errors++; $display("FAIL init_data[%0d]: got %h want 00", k, write_data); end
      checks++; if (busy !== (k < 3)) begin errors++; $display("FAIL init_busy[%0d]: got %b want %b", k, busy, (k < 3)); end
    end
    @(negedge clk); #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL idle_ready: got %b want 000", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (do_write !== 1'b0) begin errors++; $display("FAIL idle_do_write: got %b want 0", do_write); end
    @(negedge clk);
  endtask

  task automatic test_all_valid();
    int g;
    bus.req_addr  = {2'd3, 2'd2, 2'd1};
    bus.req_data  = {8'h33, 8'h22, 8'h11};
    bus.req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      g = FIXED ? 0 : (i % 3);
      #1;
      checks++; if (bus.req_ready !== 3'(1 << g)) begin errors++; $display("FAIL all_ready[%0d]: got %b want %b", i, bus.req_ready, 3'(1 << g)); end
      @(posedge clk); #1;
      checks++; if (do_write !== 1'b1) begin errors++; $display("FAIL all_do_write[%0d]: got %b want 1", i, do_write); end
      checks++; if (reg_w !== 2'(g + 1)) begin errors++; $display("FAIL all_reg_w[%0d]: got %0d want %0d", i, reg_w, g + 1); end
      checks++; if (write_data !== 8'(8'h11 * (g + 1))) begin errors++; $display("FAIL all_data[%0d]: got %h want %h", i, write_data, 8'(8'h11 * (g + 1))); end
      @(negedge clk);
    end
    bus.req_valid = 3'b000;
    g = FIXED ? 0 : 2;
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL all_drop_ready: got %b want 000", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (do_write !== 1'b0) begin errors++; $display("FAIL all_drop_do_write: got %b want 0", do_write); end
    checks++; if (reg_w !== 2'(g + 1)) begin errors++; $display("FAIL all_hold_reg_w: got %0d want %0d", reg_w, g + 1); end
    checks++; if (write_data !== 8'(8'h11 * (g + 1))) begin errors++; $display("FAIL all_hold_data: got %h want %h", write_data, 8'(8'h11 * (g + 1))); end
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.req_addr  = {2'd0, 2'd0, 2'd2};
    bus.req_data  = {8'h00, 8'h00, 8'hA5};
    bus.req_valid = 3'b001;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b want 001", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (do_write !== 1'b1) begin errors++; $display("FAIL single_do_write: got %b want 1", do_write); end
    checks++; if (reg_w !== 2'd2) begin errors++; $display("FAIL single_reg_w: got %0d want 2", reg_w); end
    checks++; if (write_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", write_data); end
    @(negedge clk);
    bus.req_valid = 3'b000;
    @(posedge clk); #1;
    checks++; if (do_write !== 1'b0) begin errors++; $display("FAIL single_after: got %b want 0", do_write); end
    @(negedge clk);
  endtask

  // Pointer sits at 1 after test_single: round-robin must skip the idle
  // requester 1, take 2, then wrap back to 0.
  task automatic test_wrap();
    logic [2:0] exp_rdy [2];
    logic [1:0] exp_reg [2];
    logic [7:0] exp_dat [2];
    if (FIXED) begin
      exp_rdy = '{3'b001, 3'b001}; exp_reg = '{2'd0, 2'd0}; exp_dat = '{8'h5A, 8'h5A};
    end else begin
      exp_rdy = '{3'b100, 3'b001}; exp_reg = '{2'd3, 2'd0}; exp_dat = '{8'hC3, 8'h5A};
    end
    bus.req_addr  = {2'd3, 2'd1, 2'd0};
    bus.req_data  = {8'hC3, 8'h77, 8'h5A};
    bus.req_valid = 3'b101;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.req_ready !== exp_rdy[i]) begin errors++; $display("FAIL wrap_ready[%0d]: got %b want %b", i, bus.req_ready, exp_rdy[i]); end
      @(posedge clk); #1;
      checks++; if (reg_w !== exp_reg[i]) begin errors++; $display("FAIL wrap_reg_w[%0d]: got %0d want %0d", i, reg_w, exp_reg[i]); end
      checks++; if (write_data !== exp_dat[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, write_data, exp_dat[i]); end
      @(negedge clk);
    end
    bus.req_valid = 3'b000;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reinit();
    bus.req_addr  = {2'd0, 2'd1, 2'd0};
    bus.req_data  = {8'h00, 8'h3C, 8'h00};
    bus.req_valid = 3'b010;
    reinit        = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reinit_ready: got %b want 000", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (do_write !== 1'b0) begin errors++; $display("FAIL reinit_no_write: got %b want 0", do_write); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reinit_busy: got %b want 1", busy); end
    @(negedge clk);
    reinit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reinit_init_ready[%0d]: got %b want 000", k, bus.req_ready); end
      @(posedge clk); #1;
      checks++; if (do_write !== 1'b1) begin errors++; $display("FAIL reinit_do_write[%0d]: got %b want 1", k, do_write); end
      checks++; if (reg_w !== 2'(k)) begin errors++; $display("FAIL reinit_reg_w[%0d]: got %0d want %0d", k, reg_w, k); end
      checks++; if (write_data !== 8'h00) begin errors++; $display("FAIL reinit_data[%0d]: got %h want 00", k, write_data); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL reinit_grant: got %b want 010", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (do_write !== 1'b1) begin errors++; $display("FAIL reinit_req_write: got %b want 1", do_write); end
    checks++; if (reg_w !== 2'd1) begin errors++; $display("FAIL reinit_req_reg_w: got %0d want 1", reg_w); end
    checks++; if (write_data !== 8'h3C) begin errors++; $display("FAIL reinit_req_data: got %h want 3c", write_data); end
    @(negedge clk);
    bus.req_valid = 3'b000;
    @(posedge clk); #1;
    checks++; if (do_write !== 1'b0) begin errors++; $display("FAIL reinit_after: got %b want 0", do_write); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_init();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (reg_w !== 2'd1) begin errors++; $display("FAIL mid_pre_reg_w: got %0d want 1", reg_w); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (do_write !== 1'b0) begin errors++; $display("FAIL mid_async_do_write: got %b want 0", do_write); end
    checks++; if (reg_w !== 2'd0) begin errors++; $display("FAIL mid_async_reg_w: got %0d want 0", reg_w); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_async_busy: got %b want 1", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (do_write !== 1'b1) begin errors++; $display("FAIL mid_do_write[%0d]: got %b want 1", k, do_write); end
      checks++; if (reg_w !== 2'(k)) begin errors++; $display("FAIL mid_reg_w[%0d]: got %0d want %0d", k, reg_w, k); end
    end
    @(posedge clk); #1;
    checks++; if (do_write !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", do_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_done: got %b want 0", busy); end
    @(negedge clk);
  endtask

  initial begin
    reinit        = 1'b0;
    bus.req_valid = 3'b000;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    test_reset();
    test_all_valid();
    test_single();
    test_wrap();
    test_reinit();
    test_reset_mid_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (reg_w / write_data / do_write) of the 4x8 register file.
- Shares that port among NREQ requesters, e.g. ALU writeback, load unit and immediate loader, using valid/ready round-robin arbitration.
- After reset, or on request, runs an init sequencer that writes INIT_VAL into every register before arbitration opens.
- Sits between the execute/load stages and register_file; drives its write inputs directly.

Parameters:
- NREQ, 3, number of requesters (2..8).
- NUM_REGS, 4, registers cleared by the init sequence.
- ADDR_W, 2, register address width.
- DATA_W, 8, register data width.
- INIT_VAL, 0, value written to each register during init.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester write request
- req_addr  input  NREQ*ADDR_W  per-requester target register; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  input  NREQ*DATA_W  per-requester write data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- reinit  input  1  pulse that restarts the init sequence
- busy  output  1  high while in INIT
- reg_w  output  ADDR_W  register file write address
- write_data  output  DATA_W  register file write data
- do_write  output  1  register file write enable

Behaviour:
- Reset values, asserted asynchronously while reset_n=0: do_write=0, reg_w=0, write_data=0, req_ready=0, rr_ptr=0, idx=0, state=INIT, busy=1.
- FSM states:
  - INIT: on each cycle drive registered outputs do_write=1, reg_w=idx, write_data=INIT_VAL, then idx++. When idx==NUM_REGS-1, move to ARB. INIT therefore lasts exactly NUM_REGS cycles. req_ready=0 throughout INIT.
  - ARB:
    - Winner is the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
    - req_ready is combinational, one-hot on the winner, all zero if no request is valid.
    - On a transfer from requester g: the next rising edge registers do_write=1, reg_w=req_addr[g], write_data=req_data[g], and sets rr_ptr=(g+1) mod NREQ.
    - If no transfer occurs, do_write=0 next cycle; reg_w and write_data hold their last values.
- Latency: a write is presented to the register file exactly 1 cycle after its handshake. Throughput is 1 write per cycle.
- Handshake rules:
  - A requester keeps valid, addr and data stable until accepted.
  - valid must not depend on ready; ready may depend on valid.
  - Dropping valid before acceptance is legal; that request is simply lost.
- reinit:
  - In ARB: reinit=1 forces req_ready=0 in that cycle, so no transfer is accepted. The next cycle enters INIT with idx=0.
  - In INIT: reinit restarts idx at 0.
  - Writes already registered complete normally.
- Reset mid-INIT or mid-ARB: the sequence restarts from idx=0 after reset_n deasserts. No partial write is issued.
- Same-address collisions cannot occur, because only one write is issued per cycle. Back-to-back writes to one register from different requesters land in grant order.
- busy = (state==INIT), decoded from the state register.
- rr_ptr width is $clog2(NREQ). It wraps from NREQ-1 to 0, and the wrap must stay correct when NREQ is not a power of two.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and stays constant at 0; everything else is unchanged.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset release -> 4 cycles with do_write=1, reg_w=0,1,2,3 and write_data=0x00, busy=1; then busy=0 and req_ready idle 0.
- After init, req0 alone valid with addr=2, data=0xA5 -> req_ready=3'b001 the same cycle; next cycle do_write=1, reg_w=2, write_data=0xA5; the following cycle do_write=0.
- All 3 requesters held valid for 6 cycles -> grants 0,1,2,0,1,2 and 6 consecutive do_write pulses. With ARB_FIXED_PRIO_EN defined -> grants 0,0,0,0,0,0.
- reinit pulsed in the same cycle as req1 valid (addr=1, data=0x3C) -> req_ready=0 that cycle; the next 4 cycles write 0x00 to regs 0..3; req1 is granted on the first ARB cycle.
- reset_n pulled low at init cycle 2 -> do_write drops to 0 asynchronously; after release the full 4-cycle init repeats starting at reg_w=0.
